// File: rtl/counter_pkg.sv
// Shared definitions for the counter family.
//   DIR_UP / DIR_DOWN : encoding of the up_dn direction input
//   terminal_value()  : count value at which a counter of the given modulus
//                       wraps when moving in the given direction
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Last value before wrap: MODULUS-1 when counting up, 0 when counting down.
  function automatic int unsigned terminal_value(input logic dir, input int unsigned modulus);
    return (dir == DIR_UP) ? (modulus - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/mod_n_step.sv
// Combinational single-step of a modulo-N up/down counter.
//   count   : current count (0..MODULUS-1)
//   up_dn   : direction, DIR_UP / DIR_DOWN
//   next_c  : count after one step in the given direction
//   wraps_c : the step crosses the terminal value and wraps around
module mod_n_step
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 12
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_c,
  output logic             wraps_c
);

  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(terminal_value(DIR_UP, MODULUS));
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(terminal_value(DIR_DOWN, MODULUS));

  // Wrap is detected by compare so MODULUS = 2**WIDTH never relies on overflow.
  always_comb begin
    next_c  = count;
    wraps_c = 1'b0;
    if (up_dn == DIR_UP) begin
      wraps_c = (count == TERM_UP);
      next_c  = wraps_c ? TERM_DN : count + WIDTH'(1);
    end else begin
      wraps_c = (count == TERM_DN);
      next_c  = wraps_c ? TERM_UP : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Parametrised modulo-N up/down counter with load, clear and terminal count.
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active-low
//   din      : parallel load value
//   load     : synchronous load (out-of-range value clamps or is rejected)
//   clr      : synchronous clear, highest priority
//   en       : count enable
//   up_dn    : direction, 1 = up, 0 = down
//   count    : current count, registered
//   tc       : terminal count, combinational, for cascading into next en
//   wrap     : registered one-cycle pulse when count wraps around
//   load_err : registered one-cycle pulse on an out-of-range load
module mod_n_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MODULUS    = 12,
  parameter bit          LOAD_CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam bit [63:0]        MAX_MOD = 64'(1) << WIDTH;
  localparam bit [63:0]        MOD_64  = 64'(MODULUS);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(terminal_value(DIR_UP, MODULUS));
  localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(terminal_value(DIR_DOWN, MODULUS));

  // Reject moduli that cannot be represented or make no sense.
  if (MOD_64 < 64'd2 || MOD_64 > MAX_MOD) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_next_c;
  logic             step_wraps_c;
  logic             din_ok_c;

  mod_n_step #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_step (
    .count  (count_q),
    .up_dn  (up_dn),
    .next_c (step_next_c),
    .wraps_c(step_wraps_c)
  );

  assign din_ok_c = ({1'b0, din} < MOD_EXT);

  // Next-state selection: clr > load > en > hold.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (din_ok_c) begin
        count_d = din;
      end else begin
        load_err_d = 1'b1;
        if (LOAD_CLAMP) count_d = TERM_UP;
      end
    end else if (en) begin
      count_d = step_next_c;
      wrap_d  = step_wraps_c;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

  // Unqualified by clr/load; the downstream stage decides how to use it.
  assign tc = en & (((up_dn == DIR_UP) & (count_q == TERM_UP)) |
                    ((up_dn == DIR_DOWN) & (count_q == TERM_DN)));

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench for mod_n_updown_counter. Four instances share stimulus:
//   0: WIDTH 4 MODULUS 12 clamp, 1: WIDTH 4 MODULUS 12 reject,
//   2: WIDTH 4 MODULUS 16 clamp, 3: WIDTH 4 MODULUS 2 clamp.
// Each queued entry names the instance whose outputs it predicts.
module tb_mod_n_updown_counter;

  typedef struct {
    int         sel;
    int         id;
    logic [3:0] cnt;
    logic       tc;
    logic       wrap;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       load, clr, en, up_dn;

  logic [3:0] cnt  [4];
  logic       tcv  [4];
  logic       wrp  [4];
  logic       lerr [4];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .LOAD_CLAMP(1'b1)) dut0 (
    .clk(clk), .rst(rst), .din(din), .load(load), .clr(clr), .en(en), .up_dn(up_dn),
    .count(cnt[0]), .tc(tcv[0]), .wrap(wrp[0]), .load_err(lerr[0]));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .LOAD_CLAMP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din), .load(load), .clr(clr), .en(en), .up_dn(up_dn),
    .count(cnt[1]), .tc(tcv[1]), .wrap(wrp[1]), .load_err(lerr[1]));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .LOAD_CLAMP(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din(din), .load(load), .clr(clr), .en(en), .up_dn(up_dn),
    .count(cnt[2]), .tc(tcv[2]), .wrap(wrp[2]), .load_err(lerr[2]));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(2), .LOAD_CLAMP(1'b1)) dut3 (
    .clk(clk), .rst(rst), .din(din), .load(load), .clr(clr), .en(en), .up_dn(up_dn),
    .count(cnt[3]), .tc(tcv[3]), .wrap(wrp[3]), .load_err(lerr[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Drive one cycle of inputs (at negedge) and queue the predicted outputs
  // seen just after the following posedge, with those inputs still applied.
  task automatic drive(input int sel, input logic c, input logic l, input logic e,
                       input logic u, input logic [3:0] d, input logic [3:0] ec,
                       input logic etc, input logic ew, input logic eerr);
    exp_t x;
    clr = c; load = l; en = e; up_dn = u; din = d;
    x.sel = sel; x.id = step_id; x.cnt = ec; x.tc = etc; x.wrap = ew; x.err = eerr;
    sb.push_back(x);
    step_id++;
    @(negedge clk);
  endtask

  // Monitor: compare the selected instance against each queued prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("count s%0d dut%0d", e.id, e.sel), int'(cnt[e.sel]), int'(e.cnt));
      check($sformatf("tc s%0d dut%0d", e.id, e.sel), int'(tcv[e.sel]), int'(e.tc));
      check($sformatf("wrap s%0d dut%0d", e.id, e.sel), int'(wrp[e.sel]), int'(e.wrap));
      check($sformatf("load_err s%0d dut%0d", e.id, e.sel), int'(lerr[e.sel]), int'(e.err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; din = '0; load = 1'b0; clr = 1'b0; en = 1'b0; up_dn = 1'b1;
    repeat (2) @(negedge clk);
    check("reset count", int'(cnt[0]), 0);
    check("reset wrap", int'(wrp[0]), 0);
    check("reset load_err", int'(lerr[0]), 0);
    rst = 1'b1;

    // Count up to 7, then asynchronous reset mid-cycle.
    for (int i = 1; i <= 7; i++) drive(0, 0, 0, 1, 1, 4'd0, 4'(i), 0, 0, 0);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async reset count", int'(cnt[0]), 0);
    check("async reset wrap", int'(wrp[0]), 0);
    check("async reset load_err", int'(lerr[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 1, 1, 4'd0, 4'd1, 0, 0, 0);

    // Up wrap through 12 edges.
    drive(0, 1, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      drive(0, 0, 0, 1, 1, 4'd0, 4'(i % 12), (i == 11), (i == 12), 0);

    // Down wrap; tc at count 0 depends on direction.
    #1;
    check("tc up at 0", int'(tcv[0]), 0);
    up_dn = 1'b0;
    #1;
    check("tc down at 0", int'(tcv[0]), 1);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd11, 0, 1, 0);

    // Loads: in range, clamped, error pulse cleared by hold and by clr.
    drive(0, 0, 1, 0, 1, 4'd10, 4'd10, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 4'd13, 4'd11, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 4'd0,  4'd11, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 4'd13, 4'd11, 0, 0, 1);
    drive(0, 1, 0, 0, 1, 4'd0,  4'd0,  0, 0, 0);
    // Rejecting instance holds its count.
    drive(1, 0, 1, 0, 1, 4'd4,  4'd4,  0, 0, 0);
    drive(1, 0, 1, 0, 1, 4'd13, 4'd4,  0, 0, 1);
    drive(1, 0, 0, 0, 1, 4'd0,  4'd4,  0, 0, 0);

    // Priority.
    drive(0, 1, 1, 1, 1, 4'd5,  4'd0,  0, 0, 0);
    drive(0, 0, 1, 1, 1, 4'd5,  4'd5,  0, 0, 0);
    drive(0, 0, 1, 0, 1, 4'd11, 4'd11, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 4'd0,  4'd11, 0, 0, 0);

    // MODULUS 16: full-range wrap by compare.
    drive(2, 1, 0, 0, 1, 4'd0,  4'd0,  0, 0, 0);
    drive(2, 0, 1, 0, 1, 4'd14, 4'd14, 0, 0, 0);
    drive(2, 0, 0, 1, 1, 4'd0,  4'd15, 1, 0, 0);
    drive(2, 0, 0, 1, 1, 4'd0,  4'd0,  0, 1, 0);
    drive(2, 0, 0, 1, 0, 4'd0,  4'd15, 0, 1, 0);

    // MODULUS 2: toggling with wrap on each return to 0.
    drive(3, 1, 0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    drive(3, 0, 0, 1, 1, 4'd0, 4'd1, 1, 0, 0);
    drive(3, 0, 0, 1, 1, 4'd0, 4'd0, 0, 1, 0);
    drive(3, 0, 0, 1, 1, 4'd0, 4'd1, 1, 0, 0);
    drive(3, 0, 0, 1, 0, 4'd0, 4'd0, 1, 0, 0);
    drive(3, 0, 0, 1, 0, 4'd0, 4'd1, 0, 1, 0);
    drive(3, 0, 1, 0, 1, 4'd3, 4'd1, 0, 0, 1);

    clr = 1'b0; load = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
